// File: rtl/alu_srca_stage.sv
// alu_srca_stage: selects and transforms ALU operand A, then queues it behind a valid/ready handshake
module alu_srca_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] reg_in,
    input  logic [WIDTH-1:0] fl_in,
    input  logic [WIDTH-1:0] imm_in,
    input  logic [WIDTH-1:0] fwd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             neg_ovf
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] last, operand, neg_val;
    logic             ovf, push, pop;
    assign neg_val = ~reg_in + WIDTH'(1);
    always_comb begin
        operand = sel == 3'd0 ? reg_in  :
                  sel == 3'd1 ? neg_val :
                  sel == 3'd2 ? fl_in   :
                  sel == 3'd3 ? '0      :
                  sel == 3'd4 ? imm_in  :
                  sel == 3'd5 ? fwd_in  :
                  sel == 3'd6 ? last    : ~reg_in;
        ovf = sel == 3'd1 && reg_in == {1'b1, {(WIDTH-1){1'b0}}};
    end
    assign in_ready  = count != (AW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign {neg_ovf, data_out} = mem[rd_ptr];
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ovf, operand};
                last        <= operand;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_alu_srca_stage.sv
// tb_alu_srca_stage: directed checks of operand selection, queue flow control and async reset
module tb_alu_srca_stage;
    logic       CLK = 0, reset = 1;
    logic       in_valid = 0, in_ready, out_valid, out_ready = 0, neg_ovf;
    logic [2:0] sel = 0;
    logic [7:0] reg_in = 0, fl_in = 0, imm_in = 0, fwd_in = 0, data_out;
    int total = 0, passed = 0;

    alu_srca_stage #(.WIDTH(8), .DEPTH(2)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .reg_in(reg_in), .fl_in(fl_in), .imm_in(imm_in), .fwd_in(fwd_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .neg_ovf(neg_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic head(input string tag, input logic [7:0] d, input logic v, input logic o);
        chk({tag, "_data"}, 32'(data_out), 32'(d));
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_ovf"}, 32'(neg_ovf), 32'(o));
    endtask

    logic [7:0] mode_exp [8] = '{8'h05, 8'hFB, 8'hA3, 8'h00, 8'h3C, 8'h77, 8'h77, 8'hFA};

    initial begin
        repeat (2) @(negedge CLK);
        reset = 0;
        head("reset", 8'h00, 0, 0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        reg_in = 8'h05; fl_in = 8'hA3; imm_in = 8'h3C; fwd_in = 8'h77; out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); in_valid = 1;
            @(negedge CLK);
            head($sformatf("mode%0d", i), mode_exp[i], 1, 0);
        end
        in_valid = 0;
        @(negedge CLK);
        chk("mode_drain_valid", 32'(out_valid), 32'd0);

        sel = 3'd1; reg_in = 8'h80; in_valid = 1;
        @(negedge CLK);
        head("neg_min", 8'h80, 1, 1);
        reg_in = 8'h7F;
        @(negedge CLK);
        head("neg_7f", 8'h81, 1, 0);
        in_valid = 0;
        @(negedge CLK);

        out_ready = 0; sel = 3'd4; in_valid = 1; imm_in = 8'h11;
        @(negedge CLK);
        chk("fill1_in_ready", 32'(in_ready), 32'd1);
        imm_in = 8'h22;
        @(negedge CLK);
        chk("fill2_in_ready", 32'(in_ready), 32'd0);
        head("fill2", 8'h11, 1, 0);
        imm_in = 8'h33;
        @(negedge CLK);
        chk("full_hold_in_ready", 32'(in_ready), 32'd0);
        head("full_hold", 8'h11, 1, 0);
        out_ready = 1;
        @(negedge CLK);
        head("pop1", 8'h22, 1, 0);
        chk("pop1_in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        head("pop2", 8'h33, 1, 0);
        in_valid = 0;
        @(negedge CLK);
        chk("fill_drain_valid", 32'(out_valid), 32'd0);

        in_valid = 1; sel = 3'd4;
        for (int i = 0; i < 20; i++) begin
            imm_in = 8'(8'h40 + i);
            @(negedge CLK);
            chk($sformatf("stream%0d_data", i), 32'(data_out), 32'(8'h40 + i));
            chk($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 0;
        @(negedge CLK);
        chk("stream_drain_valid", 32'(out_valid), 32'd0);

        reset = 1;
        @(negedge CLK);
        reset = 0;
        sel = 3'd6; in_valid = 1;
        @(negedge CLK);
        head("last_reset", 8'h00, 1, 0);
        sel = 3'd4; imm_in = 8'h3C;
        @(negedge CLK);
        head("last_load", 8'h3C, 1, 0);
        sel = 3'd6; imm_in = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            head($sformatf("last_rep%0d", i), 8'h3C, 1, 0);
        end
        in_valid = 0;
        @(negedge CLK);

        out_ready = 0; sel = 3'd1; reg_in = 8'h80; in_valid = 1;
        repeat (2) @(negedge CLK);
        in_valid = 0;
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        head("pre_rst", 8'h80, 1, 1);
        #2 reset = 1;
        #1;
        head("async_rst", 8'h00, 0, 0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        reset = 0; sel = 3'd6; in_valid = 1; out_ready = 1;
        @(negedge CLK);
        head("post_rst_last", 8'h00, 1, 0);
        in_valid = 0;
        @(negedge CLK);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
